// File: rtl/wb_pkg.sv
// Shared types and widths for the wb_master_port initiator and its bus interface.
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ACK   = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } wbm_state_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0] rdata;
    logic                 err;
  } wb_rsp_t;

endpackage

// File: rtl/wb_master_port_if.sv
// Core command/response channel plus req/we/busy/valid memory bus seen by wb_master_port.
// Command handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready && en;
// rsp_valid is a single-cycle pulse with no backpressure.
interface wb_master_port_if;
  import wb_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_we;
  logic [WB_ADDR_W-1:0] cmd_addr;
  logic [WB_DATA_W-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic [WB_DATA_W-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 req;
  logic                 we;
  logic [WB_ADDR_W-1:0] addr;
  logic [WB_DATA_W-1:0] wdata;
  logic                 busy;
  logic                 valid;
  logic [WB_DATA_W-1:0] rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, busy, valid, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, req, we, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, busy, valid, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, req, we, addr, wdata
  );

endinterface

// File: rtl/wb_master_port.sv
// Single-outstanding initiator: takes core load/store commands, runs one req/busy/valid
// bus transaction, and returns read data or an error (timeout / misalignment).
module wb_master_port
  import wb_pkg::*;
#(
  parameter int TIMEOUT     = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  wb_master_port_if.master     bus,
  output wbm_state_t           state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);

  wbm_state_t           state_q, state_d;
  logic [TW-1:0]        timer_q;
  logic                 req_q;
  logic                 we_q;
  logic [WB_ADDR_W-1:0] addr_q;
  logic [WB_DATA_W-1:0] wdata_q;
  logic                 rsp_valid_q;
  wb_rsp_t              rsp_q, rsp_d;
  logic                 cmd_ready;
  logic                 timer_exp;

  always_comb begin
    cmd_ready = (state_q == IDLE) && !bus.busy;
  end

  assign timer_exp = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          if (CHECK_ALIGN && (bus.cmd_addr[1:0] != 2'b00)) begin
            state_d = RESP;
            rsp_d   = '{rdata: '0, err: 1'b1};
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = ACK;
      // The responder registers busy a cycle after req, so ACK waits for it to appear.
      ACK: begin
        if (bus.busy) begin
          state_d = WAIT;
        end else if (timer_exp) begin
          state_d = RESP;
          rsp_d   = '{rdata: '0, err: 1'b1};
        end
      end
      WAIT: begin
        if (!bus.busy) begin
          state_d = RESP;
          if (we_q)           rsp_d = '{rdata: '0,        err: 1'b0};
          else if (bus.valid) rsp_d = '{rdata: bus.rdata, err: 1'b0};
          else                rsp_d = '{rdata: '0,        err: 1'b1};
        end else if (timer_exp) begin
          state_d = RESP;
          rsp_d   = '{rdata: '0, err: 1'b1};
        end
      end
      RESP: begin
        state_d = IDLE;
        rsp_d   = '0;
      end
      default: begin
        state_d = IDLE;
        rsp_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (en) begin
      state_q     <= state_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= (state_d == RESP);
      req_q       <= (state_q == IDLE) && (state_d == ISSUE);
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if (timer_q != TW'(TIMEOUT)) begin
        timer_q <= timer_q + TW'(1);
      end
      // Bus fields are captured only on acceptance so they hold through the whole transaction.
      if ((state_q == IDLE) && (state_d != IDLE)) begin
        we_q    <= bus.cmd_we;
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.req       = req_q;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;
  assign state_dbg     = state_q;

endmodule
